// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and line constants for the I2C bit engine
package i2c_pkg;

    localparam int   I2C_CLK_DIV = 250;
    localparam logic I2C_RELEASE = 1'b0;
    localparam logic I2C_PULL    = 1'b1;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_START1,
        ST_START2,
        ST_RESTART,
        ST_BIT_Q0,
        ST_BIT_Q1,
        ST_BIT_Q2,
        ST_BIT_Q3,
        ST_ACK_Q0,
        ST_ACK_Q1,
        ST_ACK_Q2,
        ST_ACK_Q3,
        ST_HOLD,
        ST_STOP1,
        ST_STOP2,
        ST_STOP3
    } i2c_bit_state_t;

    // Quarters in which SCL has just been released and a slave may hold it low.
    function automatic logic is_stretch_state(input i2c_bit_state_t s);
        return (s == ST_BIT_Q2) || (s == ST_ACK_Q2) || (s == ST_START1) || (s == ST_STOP2);
    endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// rtl/i2c_quarter_timer.sv - quarter-SCL-period counter with clock-stretch freeze
module i2c_quarter_timer
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = I2C_CLK_DIV,
    parameter int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic stall,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!run) begin
            cnt_d = '0;
        end else if (!stall) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_bit_engine.sv
// rtl/i2c_bit_engine.sv - bit-level I2C master: START/bit/ACK/STOP to open-drain SCL/SDA
module i2c_bit_engine
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = I2C_CLK_DIV,
    parameter int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_req,
    input  logic stop_req,
    input  logic bit_valid,
    input  logic bit_in,
    input  logic ack_req,
    output logic cmd_ready,
    output logic ack_valid,
    output logic ack_nack,
    output logic busy,
    input  logic sda_in,
    input  logic scl_in,
    output logic sda_oe,
    output logic scl_oe
);

    i2c_bit_state_t state_q, state_d;
    logic           phase_q, phase_d;
    logic           bit_q, bit_d;
    logic           sda_last_q;
    logic           ack_valid_q, ack_valid_d;
    logic           ack_nack_q, ack_nack_d;
    logic           scl_drv, sda_drv;
    logic           run, stall, tick;

    assign run   = (state_q != ST_IDLE) && (state_q != ST_HOLD);
    assign stall = is_stretch_state(state_q) && (scl_drv == I2C_RELEASE) && !scl_in;

    i2c_quarter_timer #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .stall (stall),
        .tick  (tick)
    );

    // Line levels depend only on state so the stretch path has no loop through tick.
    always_comb begin
        scl_drv = I2C_RELEASE;
        sda_drv = I2C_RELEASE;
        unique case (state_q)
            ST_START2:  sda_drv = I2C_PULL;
            ST_RESTART: scl_drv = I2C_PULL;
            ST_HOLD: begin
                scl_drv = I2C_PULL;
                sda_drv = sda_last_q;
            end
            ST_BIT_Q0, ST_BIT_Q1: begin
                scl_drv = I2C_PULL;
                sda_drv = ~bit_q;
            end
            ST_BIT_Q2, ST_BIT_Q3: sda_drv = ~bit_q;
            ST_ACK_Q0, ST_ACK_Q1: scl_drv = I2C_PULL;
            ST_STOP1: begin
                scl_drv = I2C_PULL;
                sda_drv = I2C_PULL;
            end
            ST_STOP2:   sda_drv = I2C_PULL;
            default: begin
                scl_drv = I2C_RELEASE;
                sda_drv = I2C_RELEASE;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        ack_valid_d = 1'b0;
        ack_nack_d  = ack_nack_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_req) state_d = ST_START1;
            end
            ST_START1:  if (tick) state_d = ST_START2;
            ST_START2: begin
                if (tick) begin
                    phase_d = ~phase_q;
                    if (phase_q) state_d = ST_HOLD;
                end
            end
            ST_RESTART: if (tick) state_d = ST_START1;
            ST_HOLD: begin
                if (start_req) begin
                    state_d = ST_RESTART;
                end else if (stop_req) begin
                    state_d = ST_STOP1;
                end else if (ack_req) begin
                    state_d = ST_ACK_Q0;
                end else if (bit_valid) begin
                    bit_d   = bit_in;
                    state_d = ST_BIT_Q0;
                end
            end
            ST_BIT_Q0:  if (tick) state_d = ST_BIT_Q1;
            ST_BIT_Q1:  if (tick) state_d = ST_BIT_Q2;
            ST_BIT_Q2:  if (tick) state_d = ST_BIT_Q3;
            ST_BIT_Q3:  if (tick) state_d = ST_HOLD;
            ST_ACK_Q0:  if (tick) state_d = ST_ACK_Q1;
            ST_ACK_Q1:  if (tick) state_d = ST_ACK_Q2;
            ST_ACK_Q2: begin
                if (tick) begin
                    ack_nack_d = sda_in;
                    state_d    = ST_ACK_Q3;
                end
            end
            ST_ACK_Q3: begin
                if (tick) begin
                    ack_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_STOP1:   if (tick) state_d = ST_STOP2;
            ST_STOP2:   if (tick) state_d = ST_STOP3;
            ST_STOP3: begin
                if (tick) begin
                    phase_d = ~phase_q;
                    if (phase_q) state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            bit_q       <= 1'b0;
            sda_last_q  <= I2C_RELEASE;
            ack_valid_q <= 1'b0;
            ack_nack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            sda_last_q  <= sda_drv;
            ack_valid_q <= ack_valid_d;
            ack_nack_q  <= ack_nack_d;
        end
    end

    assign cmd_ready = rst_n && ((state_q == ST_IDLE) || (state_q == ST_HOLD));
    assign busy      = (state_q != ST_IDLE);
    assign ack_valid = ack_valid_q;
    assign ack_nack  = ack_nack_q;
    assign sda_oe    = sda_drv;
    assign scl_oe    = scl_drv;

endmodule

// File: tb/tb_i2c_bit_engine.sv
// tb/tb_i2c_bit_engine.sv - scoreboard bench for i2c_bit_engine with open-drain bus model
module tb_i2c_bit_engine;

    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_req, stop_req, bit_valid, bit_in, ack_req;
    logic cmd_ready, ack_valid, ack_nack, busy;
    logic sda_in, scl_in, sda_oe, scl_oe;
    logic stretch, slave_sda, chk_stable;

    assign scl_in = ~scl_oe & ~stretch;
    assign sda_in = ~sda_oe & slave_sda;

    i2c_bit_engine #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_req (start_req),
        .stop_req  (stop_req),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .ack_req   (ack_req),
        .cmd_ready (cmd_ready),
        .ack_valid (ack_valid),
        .ack_nack  (ack_nack),
        .busy      (busy),
        .sda_in    (sda_in),
        .scl_in    (scl_in),
        .sda_oe    (sda_oe),
        .scl_oe    (scl_oe)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    logic rise_q[$];
    logic ack_q[$];
    logic cur_exp  = 1'b1;
    logic prev_scl = 1'b1;
    logic tr_scl[64];
    logic tr_sda[64];
    int   cyc;
    int   highs;
    logic [7:0] tx_byte;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command, then count cycles until the engine is ready again.
    task automatic do_cmd(input logic s, input logic p, input logic a, input logic v,
                          input logic b, input int stretch_n, output int cycles);
        int sc;
        sc     = 0;
        cycles = 0;
        @(negedge clk);
        start_req = s; stop_req = p; ack_req = a; bit_valid = v; bit_in = b;
        @(posedge clk);
        #1;
        start_req = 0; stop_req = 0; ack_req = 0; bit_valid = 0;
        if (stretch_n > 0) stretch = 1'b1;
        for (int n = 1; n < 1000; n++) begin
            @(negedge clk);
            if (n < 64) begin
                tr_scl[n] = scl_in;
                tr_sda[n] = sda_in;
            end
            if (stretch && !scl_oe) begin
                if (sc == stretch_n) stretch = 1'b0;
                else sc++;
            end
            if (cmd_ready) break;
            cycles++;
        end
        if (!cmd_ready) check("cmd_timeout", 32'(cmd_ready), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (scl_in && !prev_scl) begin
                if (rise_q.size() == 0) begin
                    check("rise_unexpected", 32'd1, 32'd0);
                end else begin
                    cur_exp = rise_q.pop_front();
                    check("sda_at_rise", 32'(sda_in), 32'(cur_exp));
                end
            end else if (scl_in && chk_stable) begin
                check("sda_stable", 32'(sda_in), 32'(cur_exp));
            end
            if (ack_valid) begin
                if (ack_q.size() == 0) check("ack_unexpected", 32'd1, 32'd0);
                else check("ack_nack", 32'(ack_nack), 32'(ack_q.pop_front()));
            end
        end
        prev_scl = scl_in;
    end

    initial begin
        rst_n = 0; start_req = 0; stop_req = 0; bit_valid = 0; bit_in = 0; ack_req = 0;
        stretch = 0; slave_sda = 1; chk_stable = 0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
            check("rst_lines", 32'({sda_oe, scl_oe, busy, ack_valid}), 32'd0);
        end
        rst_n = 1;
        @(negedge clk);
        check("idle_ready", 32'({cmd_ready, busy}), 32'b10);

        do_cmd(1, 0, 0, 0, 0, 0, cyc);
        check("start_len", cyc, 32'd12);
        check("start1_lines", 32'({tr_scl[2], tr_sda[2]}), 32'b11);
        check("start2_lines", 32'({tr_scl[6], tr_sda[6]}), 32'b10);
        check("start_hold", 32'({busy, scl_oe, sda_oe, cmd_ready}), 32'b1111);

        tx_byte = 8'hA0;
        chk_stable = 1;
        for (int i = 7; i >= 0; i--) begin
            rise_q.push_back(tx_byte[i]);
            do_cmd(0, 0, 0, 1, tx_byte[i], 0, cyc);
            check("bit_len", cyc, 32'd16);
            highs = 0;
            for (int n = 1; n <= 16; n++) highs += int'(tr_scl[n]);
            check("bit_scl_high", highs, 32'd8);
        end

        slave_sda = 0;
        rise_q.push_back(1'b0);
        ack_q.push_back(1'b0);
        do_cmd(0, 0, 1, 0, 0, 0, cyc);
        check("ack_len", cyc, 32'd16);
        slave_sda = 1;
        rise_q.push_back(1'b1);
        ack_q.push_back(1'b1);
        do_cmd(0, 0, 1, 0, 0, 0, cyc);
        check("nack_len", cyc, 32'd16);
        check("nack_held", 32'(ack_nack), 32'd1);

        rise_q.push_back(1'b0);
        do_cmd(0, 0, 0, 1, 0, 20, cyc);
        check("stretch_len", cyc, 32'd36);
        check("stretch_sda", 32'(sda_oe), 32'd1);

        chk_stable = 0;
        rise_q.push_back(1'b1);
        do_cmd(1, 0, 0, 1, 1, 0, cyc);
        check("rstart_len", cyc, 32'd16);
        check("rstart_q0", 32'({tr_scl[2], tr_sda[2]}), 32'b01);
        check("rstart_s1", 32'({tr_scl[6], tr_sda[6]}), 32'b11);
        check("rstart_s2", 32'({tr_scl[10], tr_sda[10]}), 32'b10);
        check("rstart_hold", 32'({busy, sda_oe}), 32'b11);

        rise_q.push_back(1'b0);
        do_cmd(0, 1, 0, 0, 0, 0, cyc);
        check("stop_len", cyc, 32'd16);
        check("stop1_lines", 32'({tr_scl[2], tr_sda[2]}), 32'b00);
        check("stop2_lines", 32'({tr_scl[6], tr_sda[6]}), 32'b10);
        check("stop3_lines", 32'({tr_scl[10], tr_sda[10]}), 32'b11);
        check("stop_idle", 32'({busy, sda_oe, scl_oe, cmd_ready}), 32'b0001);

        do_cmd(0, 1, 1, 1, 0, 0, cyc);
        check("idle_ignore_len", cyc, 32'd0);
        check("idle_ignore_busy", 32'(busy), 32'd0);

        do_cmd(1, 0, 0, 0, 0, 0, cyc);
        check("start2_len", cyc, 32'd12);

        @(negedge clk);
        bit_valid = 1; bit_in = 0;
        rise_q.push_back(1'b0);
        chk_stable = 1;
        @(posedge clk);
        #1;
        bit_valid = 0;
        repeat (10) @(negedge clk);
        check("mid_scl_high", 32'(scl_in), 32'd1);
        check("mid_sda_low", 32'(sda_oe), 32'd1);
        chk_stable = 0;
        rst_n = 0;
        @(posedge clk);
        #1;
        check("mid_rst_lines", 32'({sda_oe, scl_oe, busy, ack_valid, ack_nack}), 32'd0);
        @(negedge clk);
        check("mid_rst_ready", 32'(cmd_ready), 32'd0);
        rst_n = 1;
        @(negedge clk);
        check("post_rst_ready", 32'({cmd_ready, busy}), 32'b10);

        check("rise_q_empty", rise_q.size(), 32'd0);
        check("ack_q_empty", ack_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_bit_engine.md
Name: i2c_bit_engine

Overview:
Bit-level I2C master line engine sitting directly downstream of the TX controller. It converts one-bit-per-request commands (START, data bit, ACK slot, STOP) into timed open-drain SCL/SDA waveforms, and returns the sampled acknowledge bit. It also honours slave clock stretching. It replaces direct SDA/SCL wiggling by the controller; one engine serves one bus.

Parameters:
CLK_DIV, 250, clk cycles per quarter SCL period (>=2); 100 kHz SCL at 100 MHz clk.
CNT_W, $clog2(CLK_DIV), quarter counter width.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
start_req  in  1  issue START, or repeated START when bus is owned
stop_req  in  1  issue STOP
bit_valid  in  1  data bit offered
bit_in  in  1  data bit value, MSB-first order owned by the caller
ack_req  in  1  run a 9th-clock ACK slot
cmd_ready  out  1  engine in IDLE or HOLD; a command is accepted this cycle
ack_valid  out  1  one-cycle pulse; ack_nack is valid
ack_nack  out  1  sampled SDA in ACK slot (0 = ACK)
busy  out  1  bus owned (START issued, STOP not finished)
sda_in  in  1  SDA pin level
scl_in  in  1  SCL pin level (stretch detect)
sda_oe  out  1  1 = pull SDA low, 0 = release
scl_oe  out  1  1 = pull SCL low, 0 = release

Behaviour:
- Reset: sda_oe=0, scl_oe=0, busy=0, cmd_ready=0 for the reset cycle and 1 afterwards, ack_valid=0, ack_nack=0, state IDLE, quarter counter 0. Asserting reset mid-transfer releases both lines on the next edge; no STOP is generated.
- Quarter timer: counts 0..CLK_DIV-1, then emits tick and wraps. It is held at 0 in IDLE and HOLD.
- States: IDLE, START1, START2, BIT_Q0..Q3, ACK_Q0..Q3, HOLD, STOP1, STOP2, STOP3.
- IDLE: both lines released; only start_req is accepted; other requests are ignored.
- START: START1 for 1 quarter with SDA released and SCL released; START2 for 2 quarters with SDA low and SCL released; then SCL low, go to HOLD with busy=1.
- Repeated START from HOLD: release SDA with SCL low for 1 quarter, then START1.
- HOLD: SCL low; SDA keeps its last driven value. Requests are accepted with priority start_req > stop_req > ack_req > bit_valid. Lower-priority requests in the same cycle are dropped, and the caller must re-present them.
- Bit slot (4 quarters):
  - Q0: SCL low, sda_oe = ~bit_in, latched at acceptance.
  - Q1: SCL low.
  - Q2: SCL released.
  - Q3: SCL released.
  - Then HOLD. Total slot time is 4*CLK_DIV cycles from acceptance to HOLD.
- ACK slot: same timing with SDA released. sda_in is sampled on the final cycle of Q2. ack_valid pulses for 1 cycle on entry to HOLD, and ack_nack holds the sampled value until the next ACK slot.
- Clock stretch: in Q2 and START1/STOP2, while scl_oe=0 and scl_in=0, the counter freezes; it resumes when scl_in is high.
- STOP: STOP1 for 1 quarter with SCL low and SDA low; STOP2 for 1 quarter with SCL released and SDA low; STOP3 for 2 quarters with both released. Then IDLE and busy=0.
- cmd_ready is combinational from state (IDLE or HOLD). A request is accepted only in a cycle where cmd_ready=1.
- Arbitration is not checked; SDA mismatches are ignored by this block.

Decomposition:
- Shared package i2c_pkg holds:
  - state enum i2c_bit_state_t;
  - line-level constants I2C_RELEASE=0 and I2C_PULL=1;
  - default CLK_DIV.
- One sub-module, i2c_quarter_timer (ports clk, rst_n, run, stall, tick), holds the counter and stretch freeze. The FSM stays in i2c_bit_engine.

Test Plan:
- CLK_DIV=4: reset low 3 cycles, then start_req -> SDA falls while SCL high, SCL low after 12 cycles, busy=1, cmd_ready=1.
- Send bits 1,0,1,0,0,0,0,0 (0xA0) -> 8 SCL high pulses, each high for 8 cycles, with a 16-cycle bit period; SDA stable while SCL high.
- ack_req with sda_in forced 0 -> ack_valid pulse after 16 cycles, ack_nack=0. Repeat with sda_in=1 -> ack_nack=1.
- Hold scl_in low 20 cycles during a bit Q2 -> slot lengthens by exactly 20 cycles; bit_in unchanged on SDA.
- start_req and bit_valid together in HOLD -> repeated START executed, bit dropped. Then stop_req -> SDA rises while SCL high, busy=0, IDLE.
- Assert rst_n=0 mid-bit (SCL high, SDA low) -> next edge sda_oe=0, scl_oe=0, busy=0, ack_valid=0.
